// File: rtl/slicel_pkg.sv
// slicel_pkg: shared FSM state type and config-chain field offsets
package slicel_pkg;
  typedef enum logic [1:0] {UNCONF, LOAD, INIT, ACTIVE} state_e;
  function automatic int LUT_CFG_W(int s);
    return 2 * (2 ** s) + 1;
  endfunction
  function automatic int LUT_OFF(int s, int i);
    return i * LUT_CFG_W(s);
  endfunction
  function automatic int MUX_OFF(int s, int n);
    return n * LUT_CFG_W(s);
  endfunction
  function automatic int CC_OFF(int s, int n);
    return MUX_OFF(s, n) + $clog2(n);
  endfunction
  function automatic int INIT_OFF(int s, int n);
    return CC_OFF(s, n) + 1;
  endfunction
  function automatic int BYP_OFF(int s, int n);
    return INIT_OFF(s, n) + 2 * n;
  endfunction
endpackage

// File: rtl/slicel_cfgchain_if.sv
// slicel_cfgchain_if: serial config handshake; cfg_err exists only with SLICEL_CFG_PARITY_EN
interface slicel_cfgchain_if;
  logic cfg_start, cfg_valid, cfg_bit, cfg_ready, cfg_out, cfg_done;
`ifdef SLICEL_CFG_PARITY_EN
  logic cfg_err;
  modport master (output cfg_start, cfg_valid, cfg_bit, input cfg_ready, cfg_out, cfg_done, cfg_err);
  modport slave (input cfg_start, cfg_valid, cfg_bit, output cfg_ready, cfg_out, cfg_done, cfg_err);
`else
  modport master (output cfg_start, cfg_valid, cfg_bit, input cfg_ready, cfg_out, cfg_done);
  modport slave (input cfg_start, cfg_valid, cfg_bit, output cfg_ready, cfg_out, cfg_done);
`endif
endinterface

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: load FSM, bit counter, config shift register and daisy-chain output; trailing parity check with SLICEL_CFG_PARITY_EN
module slicel_cfg_loader import slicel_pkg::*; #(
  parameter int CFG_BITS = 151
) (
  input  logic                clk,
  input  logic                rst,
  slicel_cfgchain_if.slave    cfg,
  output logic [CFG_BITS-1:0] o_cfg,
  output logic                o_init,
  output logic                o_active
);
  localparam int CW = $clog2(CFG_BITS + 2);
  state_e r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [CFG_BITS-1:0] r_sr;
  logic r_out, w_ready, w_acc, w_last, w_bad, w_shift;
  assign w_ready = r_state == UNCONF || r_state == LOAD;
  assign w_acc = cfg.cfg_valid & w_ready;
`ifdef SLICEL_CFG_PARITY_EN
  logic r_par, r_err;
  assign w_last = w_acc && r_state == LOAD && r_cnt == CW'(CFG_BITS);
  assign w_bad = w_last && cfg.cfg_bit != r_par;
  assign w_shift = w_acc & ~w_last;
  assign cfg.cfg_err = r_err;
  // running even parity over config bits; sticky error until rst or a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (o_active && cfg.cfg_start) begin
        r_par <= 1'b0;
        r_err <= 1'b0;
      end else if (w_shift) r_par <= (r_state == UNCONF ? 1'b0 : r_par) ^ cfg.cfg_bit;
      if (w_bad) r_err <= 1'b1;
    end
  end
`else
  assign w_last = w_acc && r_state == LOAD && r_cnt == CW'(CFG_BITS - 1);
  assign w_bad = 1'b0;
  assign w_shift = w_acc;
`endif
  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_done = o_active;
  assign cfg.cfg_out = r_out;
  assign o_cfg = r_sr;
  // next state, bit counter and state flags
  always_comb begin
    w_nxt = r_state;
    w_cnt = w_acc ? r_cnt + 1'b1 : r_cnt;
    o_init = r_state == INIT;
    o_active = r_state == ACTIVE;
    if (r_state == UNCONF && w_acc) begin
      w_nxt = LOAD;
      w_cnt = CW'(1);
    end
    if (w_last) w_nxt = w_bad ? UNCONF : INIT;
    if (o_init) w_nxt = ACTIVE;
    if (o_active && cfg.cfg_start) begin
      w_nxt = LOAD;
      w_cnt = '0;
    end
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNCONF;
      r_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt;
    end
  end
  // shift right on each accepted config bit, LSB leaves toward the next slice
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
      r_out <= 1'b0;
    end else if (w_shift) begin
      r_sr <= {cfg.cfg_bit, r_sr[CFG_BITS-1:1]};
      r_out <= r_sr[0];
    end
  end
endmodule

// File: rtl/slicel_cfgchain.sv
// slicel_cfgchain: fractured-LUT slice with carry chain, F-mux tree and bypassable output registers, serially configured (parity with SLICEL_CFG_PARITY_EN)
module slicel_cfgchain import slicel_pkg::*; #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS = 4,
  parameter int MUX_LVLS = $clog2(NUM_LUTS),
  parameter int LUT_CFG = 2 * (2 ** S_XX_BASE) + 1,
  parameter int CFG_BITS = NUM_LUTS * LUT_CFG + MUX_LVLS + 1 + 4 * NUM_LUTS
) (
  input  logic                            clk,
  input  logic                            rst,
  slicel_cfgchain_if.slave                cfg,
  input  logic [2*S_XX_BASE*NUM_LUTS-1:0] luts_in,
  input  logic [MUX_LVLS-1:0]             higher_order_addr,
  input  logic                            reg_ce,
  input  logic                            ci,
  output logic                            co,
  output logic [2*NUM_LUTS-1:0]           out,
  output logic [2*NUM_LUTS-1:0]           sync_out
);
  localparam int S = S_XX_BASE;
  localparam int N = NUM_LUTS;
  logic [CFG_BITS-1:0] w_cfg;
  logic w_init, w_active, w_cc;
  logic [MUX_LVLS-1:0] w_mux;
  logic [2*N-1:0] w_byp, w_rinit, w_comb, r_sync;
  logic [N-1:0] w_p, w_g, w_m;
  logic [N:0] w_c;
  slicel_cfg_loader #(.CFG_BITS(CFG_BITS)) u_loader (
    .clk(clk), .rst(rst), .cfg(cfg), .o_cfg(w_cfg), .o_init(w_init), .o_active(w_active)
  );
  assign w_mux = w_cfg[MUX_OFF(S, N) +: MUX_LVLS];
  assign w_cc = w_cfg[CC_OFF(S, N)];
  assign w_rinit = w_cfg[INIT_OFF(S, N) +: 2*N];
  assign w_byp = w_cfg[BYP_OFF(S, N) +: 2*N];
  for (genvar i = 0; i < N; i++) begin : g_lut
    logic [2*S-1:0] w_a;
    logic [2**S-1:0] w_t0, w_t1;
    logic w_mode;
    assign w_a = luts_in[2*S*i +: 2*S];
    assign {w_mode, w_t1, w_t0} = w_cfg[LUT_OFF(S, i) +: LUT_CFG];
    assign w_g[i] = w_t1[w_a[2*S-1:S]];
    assign w_p[i] = (w_mode & w_a[S]) ? w_t1[w_a[S-1:0]] : w_t0[w_a[S-1:0]];
    assign w_comb[2*i] = w_cc ? w_p[i] ^ w_c[i] : w_m[i];
    assign w_comb[2*i+1] = w_g[i];
  end
  // ripple carry, then F-mux tree folded in place; odd-multiple slots are never overwritten within a level
  always_comb begin
    w_c[0] = ci;
    for (int i = 0; i < N; i++) w_c[i+1] = w_p[i] ? w_c[i] : w_g[i];
    w_m = w_p;
    for (int l = 0; l < MUX_LVLS; l++)
      for (int i = 0; i < N; i += 2 ** (l + 1))
        w_m[i] = (w_mux[l] & higher_order_addr[l]) ? w_m[i + 2 ** l] : w_m[i];
  end
  // output registers: preset from config on INIT, capture when enabled in ACTIVE
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else if (w_init) r_sync <= w_rinit;
    else if (w_active && reg_ce) r_sync <= w_comb;
  end
  assign co = w_active & w_c[N];
  assign out = w_active ? (w_byp & w_comb) | (~w_byp & r_sync) : '0;
  assign sync_out = r_sync;
endmodule
